// File: rtl/dice_race_turn_ctrl_if.sv
// Bundle between the roll source and the turn controller.
// The slave side is the controller; the master side drives the rolls and observes game state.
interface dice_race_turn_ctrl_if #(
  parameter int POS_W = 5
);
  logic             start;
  logic             color_result_ready;
  logic [1:0]       movement_steps;
  logic             cur_player;
  logic [POS_W-1:0] pos_p0;
  logic [POS_W-1:0] pos_p1;
  logic             step_pulse;
  logic             busy;
  logic             winner_valid;
  logic             winner_id;
  logic [2:0]       state_o;

  modport slave (
    input  start, color_result_ready, movement_steps,
    output cur_player, pos_p0, pos_p1, step_pulse, busy, winner_valid, winner_id, state_o
  );

  modport master (
    output start, color_result_ready, movement_steps,
    input  cur_player, pos_p0, pos_p1, step_pulse, busy, winner_valid, winner_id, state_o
  );
endinterface

// File: rtl/dice_race_turn_ctrl.sv
// Two-player race sequencer: one roll per turn, squares advanced one at a time
// with a fixed dwell between squares, winner detection and turn alternation.
module dice_race_turn_ctrl #(
  parameter int BOARD_LEN  = 20,
  parameter int STEP_TICKS = 12_500_000,
  parameter int POS_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  dice_race_turn_ctrl_if.slave  bus
);
  localparam int TMR_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_ROLL  = 3'd1,
    MOVE       = 3'd2,
    STEP_WAIT  = 3'd3,
    WAIT_CLEAR = 3'd4,
    WIN        = 3'd5
  } state_e;

  state_e                 state_q;
  logic [1:0][POS_W-1:0]  pos_q;
  logic                   cur_q;
  logic                   step_pulse_q;
  logic                   winner_id_q;
  logic [1:0]             steps_q;
  logic [TMR_W-1:0]       timer_q;
  logic [POS_W-1:0]       step_pos_d;

  // Position the current player lands on if a square is taken this cycle.
  assign step_pos_d = pos_q[cur_q] + POS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      cur_q        <= 1'b0;
      step_pulse_q <= 1'b0;
      winner_id_q  <= 1'b0;
      steps_q      <= '0;
      timer_q      <= '0;
    end else begin
      step_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) state_q <= WAIT_ROLL;
        end
        WAIT_ROLL: begin
          if (bus.color_result_ready && bus.movement_steps != 2'd0) begin
            steps_q <= bus.movement_steps;
            state_q <= MOVE;
          end
        end
        MOVE: begin
          if (steps_q == 2'd0) begin
            state_q <= WAIT_CLEAR;
          end else begin
            pos_q[cur_q] <= step_pos_d;
            step_pulse_q <= 1'b1;
            steps_q      <= steps_q - 2'd1;
            if (step_pos_d == POS_W'(BOARD_LEN)) begin
              // Landing on the goal ends the game; leftover squares are dropped.
              winner_id_q <= cur_q;
              steps_q     <= '0;
              state_q     <= WIN;
            end else begin
              timer_q <= TMR_W'(STEP_TICKS - 1);
              state_q <= STEP_WAIT;
            end
          end
        end
        STEP_WAIT: begin
          if (timer_q == '0) state_q <= MOVE;
          else               timer_q <= timer_q - TMR_W'(1);
        end
        WAIT_CLEAR: begin
          // Only an empty-tray result hands over the turn, so a lingering die is not re-counted.
          if (bus.color_result_ready && bus.movement_steps == 2'd0) begin
            cur_q   <= ~cur_q;
            state_q <= WAIT_ROLL;
          end
        end
        WIN: begin
          if (bus.start) begin
            pos_q   <= '0;
            cur_q   <= 1'b0;
            state_q <= WAIT_ROLL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cur_player   = cur_q;
  assign bus.pos_p0       = pos_q[0];
  assign bus.pos_p1       = pos_q[1];
  assign bus.step_pulse   = step_pulse_q;
  assign bus.busy         = (state_q == MOVE) || (state_q == STEP_WAIT);
  assign bus.winner_valid = (state_q == WIN);
  assign bus.winner_id    = winner_id_q;
  assign bus.state_o      = state_q;
endmodule

// File: tb/tb_dice_race_turn_ctrl.sv
// Directed bench for the race turn controller with a timestamp-based game model
// compared against the outputs every cycle, plus hand-computed scenario checks.
module tb_dice_race_turn_ctrl;
  localparam int BL = 8;
  localparam int ST = 4;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dice_race_turn_ctrl_if #(.POS_W(PW)) io();

  dice_race_turn_ctrl #(.BOARD_LEN(BL), .STEP_TICKS(ST), .POS_W(PW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (io.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Game model: phase 0 idle, 1 awaiting roll, 2 moving, 3 awaiting clear, 4 won.
  int m_phase = 0;
  int m_pos[2];
  int m_cur = 0;
  int m_wid = 0;
  int m_pulse = 0;
  int due[$];
  int clear_at = -1;
  int pulse_q[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    m_pulse = 0;
    if (rst) begin
      m_phase = 0; m_pos[0] = 0; m_pos[1] = 0; m_cur = 0; m_wid = 0;
      due.delete(); clear_at = -1;
    end else begin
      case (m_phase)
        0: if (io.start) m_phase = 1;
        1: if (io.color_result_ready && io.movement_steps != 0) begin
             m_phase = 2;
             for (int k = 0; k < int'(io.movement_steps); k++) due.push_back(cyc + 1 + k * (ST + 1));
           end
        2: if (due.size() > 0 && due[0] == cyc) begin
             void'(due.pop_front());
             m_pos[m_cur]++;
             m_pulse = 1;
             if (m_pos[m_cur] == BL) begin
               m_phase = 4; m_wid = m_cur; due.delete();
             end else if (due.size() == 0) begin
               clear_at = cyc + ST + 1;
             end
           end else if (due.size() == 0 && cyc == clear_at) begin
             m_phase = 3;
           end
        3: if (io.color_result_ready && io.movement_steps == 0) begin
             m_cur = 1 - m_cur; m_phase = 1;
           end
        4: if (io.start) begin
             m_pos[0] = 0; m_pos[1] = 0; m_cur = 0; m_phase = 1;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  function automatic int exp_state();
    int nxt;
    case (m_phase)
      0: return 0;
      1: return 1;
      2: begin
           nxt = (due.size() > 0) ? due[0] : clear_at;
           return (nxt == cyc + 1) ? 2 : 3;
         end
      3: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic compare();
    if (io.step_pulse) pulse_q.push_back(cyc);
    chk("cur_player",   int'(io.cur_player),   m_cur);
    chk("pos_p0",       int'(io.pos_p0),       m_pos[0]);
    chk("pos_p1",       int'(io.pos_p1),       m_pos[1]);
    chk("step_pulse",   int'(io.step_pulse),   m_pulse);
    chk("busy",         int'(io.busy),         (m_phase == 2) ? 1 : 0);
    chk("winner_valid", int'(io.winner_valid), (m_phase == 4) ? 1 : 0);
    if (m_phase == 4) chk("winner_id", int'(io.winner_id), m_wid);
    chk("state_o",      int'(io.state_o),      exp_state());
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse_start();
    io.start = 1'b1; tick(); io.start = 1'b0;
  endtask

  task automatic pulse_ready(input int s);
    io.color_result_ready = 1'b1; io.movement_steps = 2'(s);
    tick();
    io.color_result_ready = 1'b0; io.movement_steps = 2'd0;
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(io.state_o) != s && n < budget) begin
      tick(); n++;
    end
    chk(nm, int'(io.state_o), s);
  endtask

  task automatic turn(input int s);
    pulse_ready(s);
    wait_state(4, 40, "turn_clear");
    pulse_ready(0);
  endtask

  initial begin
    int base, r;
    m_pos[0] = 0; m_pos[1] = 0;
    io.start = 1'b0; io.color_result_ready = 1'b0; io.movement_steps = 2'd0;

    // 1: reset, then a roll in IDLE must be ignored
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("rst_state", int'(io.state_o), 0);
    chk("rst_pos_p0", int'(io.pos_p0), 0);
    chk("rst_winner", int'(io.winner_valid), 0);
    pulse_ready(2); tick();
    chk("idle_ready_state", int'(io.state_o), 0);
    chk("idle_ready_pos", int'(io.pos_p0), 0);

    // 2: player 0 rolls 3
    pulse_start();
    chk("start_state", int'(io.state_o), 1);
    base = pulse_q.size();
    pulse_ready(3); r = cyc;
    wait_state(4, 40, "s2_clear");
    chk("s2_pulses", pulse_q.size() - base, 3);
    if (pulse_q.size() - base == 3) begin
      chk("s2_latency", pulse_q[base] - r, 1);
      chk("s2_gap1", pulse_q[base+1] - pulse_q[base], 5);
      chk("s2_gap2", pulse_q[base+2] - pulse_q[base+1], 5);
    end
    chk("s2_pos_p0", int'(io.pos_p0), 3);
    pulse_ready(0);
    chk("s2_cur", int'(io.cur_player), 1);
    chk("s2_state", int'(io.state_o), 1);

    // 3: player 1 rolls 2, a roll during the dwell is dropped
    base = pulse_q.size();
    pulse_ready(2);
    wait_state(3, 10, "s3_stepwait");
    pulse_ready(3);
    wait_state(4, 40, "s3_clear");
    chk("s3_pos_p1", int'(io.pos_p1), 2);
    chk("s3_pulses", pulse_q.size() - base, 2);
    chk("s3_pos_p0", int'(io.pos_p0), 3);

    // 4: a die still present in WAIT_CLEAR does not end the turn
    pulse_ready(1); tick();
    chk("s4_state", int'(io.state_o), 4);
    pulse_ready(0);
    chk("s4_cur", int'(io.cur_player), 0);

    // 5: bring player 0 to 7, then overshoot roll wins with one step
    turn(3); turn(1); turn(1); turn(1);
    chk("s5_pos_p0", int'(io.pos_p0), 7);
    chk("s5_pos_p1", int'(io.pos_p1), 4);
    chk("s5_cur", int'(io.cur_player), 0);
    base = pulse_q.size();
    pulse_ready(3);
    wait_state(5, 20, "s5_win");
    repeat (12) tick();
    chk("s5_pulses", pulse_q.size() - base, 1);
    chk("s5_pos_win", int'(io.pos_p0), 8);
    chk("s5_wv", int'(io.winner_valid), 1);
    chk("s5_wid", int'(io.winner_id), 0);
    pulse_ready(2); pulse_ready(0); tick();
    chk("s5_frozen_state", int'(io.state_o), 5);
    chk("s5_frozen_pos", int'(io.pos_p0), 8);

    // 6: restart from WIN, then reset mid-dwell, then start+ready together in IDLE
    pulse_start();
    chk("s6_state", int'(io.state_o), 1);
    chk("s6_pos_p0", int'(io.pos_p0), 0);
    chk("s6_pos_p1", int'(io.pos_p1), 0);
    chk("s6_wv", int'(io.winner_valid), 0);
    pulse_ready(2);
    wait_state(3, 10, "s6_stepwait");
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_rst_state", int'(io.state_o), 0);
    chk("s6_rst_pos", int'(io.pos_p0), 0);
    chk("s6_rst_busy", int'(io.busy), 0);
    io.start = 1'b1; io.color_result_ready = 1'b1; io.movement_steps = 2'd2;
    tick();
    io.start = 1'b0; io.color_result_ready = 1'b0; io.movement_steps = 2'd0;
    repeat (3) tick();
    chk("s6_sr_state", int'(io.state_o), 1);
    chk("s6_sr_pos", int'(io.pos_p0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
